start_pulse_gen: RTL

- Upstream conditioning stage for the sequencing FSM. Converts a raw, asynchronous, bouncing push-button/trigger input into a clean single-cycle `start` pulse in the `clk` domain.
- Signal chain: 2-FF synchronizer → debounce counter → press/release state machine → post-release holdoff.
- Also reports the debounced level, a wrapping pulse count, and a sticky flag for presses dropped while the FSM was busy.

---
 rtl/start_pulse_gen.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/start_pulse_gen.sv
// -----------------------------------------------------------------------------
// start_pulse_gen
//
// Turns a raw, asynchronous, bouncing push-button or trigger input into one
// clean single-cycle start pulse in the clk domain.
//
// Signal chain:
//   btn_in -> polarity fix -> 2-FF synchronizer -> debounce counter
//          -> press/release state machine -> post-release holdoff
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples needed to accept
//                     a press or a release (2 .. 2**CNT_W-1)
//   HOLDOFF_CYCLES  : cycles after an accepted release during which the input
//                     is ignored (0 = no holdoff)
//   CNT_W           : width of the shared debounce/holdoff counter
//   BTN_ACTIVE_LOW  : 1 means btn_in = 0 is "pressed"
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   btn_in      in   raw asynchronous button/trigger
//   fsm_busy    in   downstream FSM running; an accepted press is dropped
//   start       out  registered single-cycle start pulse
//   btn_level   out  debounced pressed level
//   pulse_count out  number of start pulses issued, wraps 255 -> 0
//   dropped     out  sticky: a press was accepted while fsm_busy = 1
// -----------------------------------------------------------------------------
module start_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 4,
  parameter int CNT_W           = 8,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       fsm_busy,
  output logic       start,
  output logic       btn_level,
  output logic [7:0] pulse_count,
  output logic       dropped
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT,
    HOLDOFF
  } state_t;

  // Counter value seen on the edge that completes a debounce window or the
  // holdoff. The holdoff constant is clamped so a zero holdoff still yields a
  // legal (never used) value.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  // ---------------------------------------------------------------------------
  // Polarity normalisation and 2-FF synchronizer. Internally 1 = pressed, so
  // the reset value 0 of both flops means "released".
  // ---------------------------------------------------------------------------
  logic btn_pressed_raw;
  logic sync_meta;
  logic sync_s;

  assign btn_pressed_raw = btn_in ^ BTN_ACTIVE_LOW;

  // NOTE: every clocked register uses non-blocking assignments so that all
  // flops sample their inputs from the same edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= btn_pressed_raw;
      sync_s    <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Press/release state machine with a shared debounce/holdoff counter.
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;  // press debounce completes on this edge

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sync_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end

      PRESS_WAIT: begin
        if (!sync_s) begin
          // Bounce on the way in: drop back and start counting from scratch.
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!sync_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end

      RELEASE_WAIT: begin
        if (sync_s) begin
          // Bounce on the way out: the press is still the same press, so no
          // new pulse is ever issued from here.
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DEB_LAST) begin
          state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HOLDOFF: begin
        // Input ignored; only time advances.
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. fsm_busy is looked at only on the acceptance edge, so a
  // later busy-to-idle change never produces a late pulse.
  // ---------------------------------------------------------------------------
  logic issue;
  logic drop;

  assign issue = accept & ~fsm_busy;
  assign drop  = accept &  fsm_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start       <= 1'b0;
      btn_level   <= 1'b0;
      pulse_count <= 8'd0;
      dropped     <= 1'b0;
    end else begin
      // start is rebuilt every edge, so it can never stay high past one cycle.
      start     <= issue;
      btn_level <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      if (issue) begin
        pulse_count <= pulse_count + 8'd1;  // modulo 256
      end
      if (drop) begin
        dropped <= 1'b1;
      end
    end
  end

endmodule
